// File: rtl/access_sequencer_if.sv
// Handshake and status bundle between an access requester and access_sequencer.
// The master side drives run control and memory responses; the slave side is the sequencer.
interface access_sequencer_if;
  logic        start;
  logic        hit;
  logic        miss;
  logic [14:0] address;
  logic        busy;
  logic        done;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic        error;

  modport master (
    output start, hit, miss,
    input  address, busy, done, hit_count, miss_count, error
  );

  modport slave (
    input  start, hit, miss,
    output address, busy, done, hit_count, miss_count, error
  );
endinterface

// File: rtl/access_sequencer.sv
// access_sequencer: walks NUM_ACC consecutive addresses from START_ADDR, waiting for a
// hit on each and classifying every access as clean hit or miss.
// Optional watchdog: define ACCESS_TIMEOUT_EN to abort a run when one access waits
// TIMEOUT cycles without a hit (sets sticky error, forces DONE).
module access_sequencer #(
  parameter logic [14:0] START_ADDR = 15'd0,
  parameter logic [15:0] NUM_ACC    = 16'd1024,
  parameter logic [15:0] TIMEOUT    = 16'd64
) (
  input  logic               clk,
  input  logic               rst,
  access_sequencer_if.slave  bus
);

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Reject configurations that cannot run.
  if (NUM_ACC == 16'd0) begin : g_bad_num_acc
    $error("access_sequencer: NUM_ACC must be in 1..65535");
  end
  if (TIMEOUT == 16'd0) begin : g_bad_timeout
    $error("access_sequencer: TIMEOUT must be nonzero");
  end

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               seen_q, seen_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               busy_q, done_q;
`ifdef ACCESS_TIMEOUT_EN
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               err_q, err_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Next-state and next-value logic for the run sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    seen_d     = seen_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
`ifdef ACCESS_TIMEOUT_EN
    wait_d     = wait_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_ACCESS;
          addr_d     = START_ADDR;
          idx_d      = '0;
          seen_d     = 1'b0;
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
`ifdef ACCESS_TIMEOUT_EN
          wait_d     = '0;
          err_d      = 1'b0;
`endif
        end
      end
      S_ACCESS: begin
        if (bus.hit) begin
          // A miss seen at any point during the access, or alongside the hit, taints it.
          if (seen_q || bus.miss) miss_cnt_d = sat_inc(miss_cnt_q);
          else                    hit_cnt_d  = sat_inc(hit_cnt_q);
          if (idx_q == NUM_ACC - CNT_W'(1)) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + CNT_W'(1);
            addr_d = addr_q + ADDR_W'(1);
            seen_d = 1'b0;
`ifdef ACCESS_TIMEOUT_EN
            wait_d = '0;
`endif
          end
        end else begin
          if (bus.miss) seen_d = 1'b1;
`ifdef ACCESS_TIMEOUT_EN
          wait_d = wait_q + CNT_W'(1);
          if (wait_d == TIMEOUT) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= START_ADDR;
      idx_q      <= '0;
      seen_q     <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ACCESS_TIMEOUT_EN
      wait_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      seen_q     <= seen_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      busy_q     <= (state_d == S_ACCESS);
      done_q     <= (state_d == S_DONE);
`ifdef ACCESS_TIMEOUT_EN
      wait_q     <= wait_d;
      err_q      <= err_d;
`endif
    end
  end

  assign bus.address    = addr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
`ifdef ACCESS_TIMEOUT_EN
  assign bus.error      = err_q;
`else
  assign bus.error      = 1'b0;
`endif

endmodule

// File: doc/access_sequencer.md
ACCESS_SEQUENCER -- requirements
Module: access_sequencer

Interface
REQ-001 Parameter START_ADDR, default 15'd0: first address issued in a run.
REQ-002 Parameter NUM_ACC, default 16'd1024: accesses per run, legal range 1..65535.
REQ-003 Parameter TIMEOUT, default 16'd64: max cycles one access may wait for hit; only used with ACCESS_TIMEOUT_EN.
REQ-004 Port clk  input  1: single clock, all state updates on rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port start  input  1: begins a run when sampled high in IDLE or DONE.
REQ-007 Port hit  input  1: cache hit from downstream memory; completes the current access.
REQ-008 Port miss  input  1: cache miss from downstream memory; marks current access as a miss.
REQ-009 Port address  output  15: address driven to the memory stage, registered.
REQ-010 Port busy  output  1: high while in ACCESS state.
REQ-011 Port done  output  1: high while in DONE state.
REQ-012 Port hit_count  output  16: accesses completed without any miss in the current/last run.
REQ-013 Port miss_count  output  16: accesses that saw miss at least once.
REQ-014 Port error  output  1: sticky watchdog flag.

Function
REQ-015 FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-016 IDLE/DONE with start=1: next state ACCESS, address<=START_ADDR, hit_count, miss_count, index, miss_seen, wait counter and error cleared in same edge.
REQ-017 start SHALL be ignored while in ACCESS.
REQ-018 ACCESS edge with hit=1: access completes; miss_count+1 if miss_seen=1 or miss=1 that cycle, else hit_count+1.
REQ-019 On completion with index=NUM_ACC-1: next state DONE, address held; otherwise index+1, address+1, miss_seen<=0, wait counter<=0.
REQ-020 Address increment SHALL wrap modulo 2^15 (15'h7FFF -> 15'h0000) without affecting index or counts.
REQ-021 ACCESS edge with hit=0 and miss=1: miss_seen<=1; address held; no count change.
REQ-022 ACCESS edge with hit=0 and miss=0: address held; no count change.
REQ-023 hit and miss in IDLE or DONE SHALL be ignored.
REQ-024 hit_count+miss_count SHALL equal NUM_ACC when DONE is entered normally.
REQ-025 Counters SHALL saturate at 16'hFFFF (unreachable for legal NUM_ACC; defensive).
REQ-026 Address SHALL change only on the edge that completes an access or starts a run; stable otherwise.
REQ-027 DONE SHALL persist until start or rst.

Reset
REQ-028 rst=1 on an edge: state IDLE, address=START_ADDR, busy=0, done=0, hit_count=0, miss_count=0, error=0, miss_seen=0, index=0, wait counter=0.
REQ-029 rst SHALL take priority over start, hit and miss on the same edge, including mid-run in ACCESS.

Configuration
REQ-030 Macro ACCESS_TIMEOUT_EN defined: wait counter increments each ACCESS cycle with hit=0; reaching TIMEOUT sets error=1 and forces DONE; counts retain values.
REQ-031 ACCESS_TIMEOUT_EN undefined: no wait counter logic, error tied 0, ACCESS waits indefinitely for hit.

Verification
REQ-032 NUM_ACC=4, START_ADDR=0, memory stub hit=1 every cycle from ACCESS -> addresses 0,1,2,3 one per cycle, hit_count=4, miss_count=0, done=1 after 4th hit.
REQ-033 NUM_ACC=2, stub: miss=1 one cycle, 3 idle cycles, hit=1; repeat -> address 0 held 5 cycles, then 1; miss_count=2, hit_count=0.
REQ-034 START_ADDR=15'h7FFE, NUM_ACC=4, hit every cycle -> addresses 7FFE,7FFF,0000,0001; hit_count=4.
REQ-035 NUM_ACC=8, rst=1 asserted after 3rd hit -> next cycle state IDLE, address=START_ADDR, all counts 0, busy=0.
REQ-036 ACCESS_TIMEOUT_EN, TIMEOUT=16, stub never hits -> error=1 and done=1 after 16 ACCESS cycles; without macro busy stays 1 for 100 cycles.
REQ-037 Same-cycle hit=1 and miss=1 on 1st access, start pulsed mid-run -> miss_count=1, start has no effect until DONE.
